mac_stream_sender: RTL and testbench
====================================

Name: mac_stream_sender

Overview:
- Transmit end of the staged-MAC input stream.
- Accepts one job descriptor (16-bit signed bias, operand count N) and then N int8 operand pairs from an upstream operand port.
- Emits the framed 16-bit AXI-Stream the plexed MAC consumes:
  - beat 0 = bias;
  - beats 1..N = packed {A, B} pairs;
  - TLAST on the final beat.
- Sits between the operand buffers / DMA and the MAC's SD_AXIS slave port.

Parameters:
- CNT_W, 16, width of the operand-count field; max N = 2^CNT_W-1.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  reset, synchronous, active-low.
- CMD_VALID  in  1  job descriptor valid.
- CMD_READY  out  1  descriptor accepted when CMD_VALID & CMD_READY.
- CMD_BIAS  in  16  signed bias, sent verbatim as beat 0.
- CMD_COUNT  in  CNT_W  number of operand pairs N (0 legal).
- OP_VALID  in  1  operand pair valid.
- OP_READY  out  1  operand pair accepted when OP_VALID & OP_READY.
- OP_A  in  8  signed operand, placed in TDATA[15:8].
- OP_B  in  8  signed operand, placed in TDATA[7:0].
- MO_AXIS_TVALID  out  1  stream beat valid.
- MO_AXIS_TDATA  out  16  stream beat data.
- MO_AXIS_TLAST  out  1  last beat of frame.
- MO_AXIS_TREADY  in  1  downstream (MAC SD_AXIS_TREADY) ready.
- BUSY  out  1  high while in OPS state or MO_AXIS_TVALID high.

Behaviour:
- Reset (ARESETN=0 at a rising edge):
  - state=IDLE; MO_AXIS_TVALID=0, TLAST=0, TDATA=0; remaining=0; BUSY=0.
  - CMD_READY and OP_READY read 0 while ARESETN=0.
- Output register (single stage):
  - free = !MO_AXIS_TVALID | MO_AXIS_TREADY.
  - A load sets TVALID=1 with new TDATA/TLAST.
  - If free and no load, TVALID clears next cycle.
  - TDATA/TLAST are held stable while TVALID & !TREADY (AXIS rule).
- States:
  - IDLE:
    - CMD_READY = free; OP_READY=0.
    - On command handshake, load bias beat: TDATA=CMD_BIAS, TLAST=(CMD_COUNT==0).
    - If CMD_COUNT==0, stay IDLE; else remaining=CMD_COUNT and go to OPS.
  - OPS:
    - OP_READY = free; CMD_READY=0.
    - On operand handshake, load TDATA={OP_A,OP_B}, TLAST=(remaining==1), remaining--.
    - If remaining==1, go to IDLE.
- Latency: command or operand handshake at edge k produces that beat on MO_AXIS with TVALID=1 after edge k (visible in cycle k+1).
- Throughput: 1 beat/cycle with continuous TREADY and OP_VALID.
  - A back-to-back next command is accepted in the same cycle the last operand beat drains; no bubble between frames.
- CMD_READY and OP_READY are combinational on MO_AXIS_TREADY (no ready-to-ready register). Upstream must not make VALID depend on READY.
- Operand gaps: OP_VALID low in OPS inserts idle cycles (TVALID=0); framing is unaffected.
- OP_VALID in IDLE is ignored (not accepted). CMD_VALID in OPS is held off.
- remaining is unsigned CNT_W bits. N=2^CNT_W-1 must produce exactly N operand beats; no wrap.
- Reset mid-frame aborts immediately: outputs go to reset values, the partial frame ends without TLAST, and upstream/downstream must be reset in the same cycle.
- No arithmetic on data; bias and operands pass bit-exact.

Decomposition:
- Package mac_stream_pkg contains:
  - state enum {IDLE, OPS};
  - BEAT_W=16 and OPND_W=8 constants;
  - a pack_pair(a,b) function returning {a,b}.
- One sub-module, axis_out_stage: the single output register with free/load/hold logic, reused by later stream sources.

Test Plan:
- Basic frame: cmd bias=5, N=2; ops (-10,5), (25,100); TREADY=1 → beats 0x0005, 0xF605, 0x1964 with TLAST on the third only. Feeding the MAC yields result 2455.
- Zero-length: cmd bias=-2000, N=0 → single beat 0xF830 with TLAST=1; OP_READY never asserts; CMD_READY high next cycle.
- Backpressure: N=3, TREADY pattern 1,0,0,1,0,1,1 → TDATA/TLAST stable during every stall; exactly 4 beats; no beat duplicated or lost; OP_READY low during stalls.
- Back-to-back: two frames (bias 1, N=1, op (2,3)) then (bias -1, N=1, op (-128,-128)), all valids high → beats 0x0001, 0x0203(L), 0xFFFF, 0x8080(L) on 4 consecutive cycles.
- Operand gaps: N=3, OP_VALID low 2 cycles between pairs → TVALID low in the gaps; TLAST only on the third pair; BUSY high throughout until the last beat is accepted.
- Reset mid-frame: assert ARESETN=0 after the bias and 1 of 3 pairs → next edge TVALID=0, state IDLE; after release a new frame (bias 7, N=0) emits 0x0007 with TLAST.

Source files
------------

// File: rtl/mac_stream_sender_pkg.sv
// Shared types, widths and helpers for the MAC input stream sources.
package mac_stream_pkg;

  localparam int unsigned BEAT_W = 16;
  localparam int unsigned OPND_W = 8;

  // Frame position: IDLE waits for a descriptor, OPS streams operand pairs.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OPS  = 1'b1
  } state_e;

  // Operand pair beat layout: A in the upper byte, B in the lower byte.
  function automatic logic [BEAT_W-1:0] pack_pair(input logic [OPND_W-1:0] a,
                                                  input logic [OPND_W-1:0] b);
    return {a, b};
  endfunction

endpackage

// File: rtl/mac_stream_sender_if.sv
// Descriptor, operand and AXI-Stream signals of the MAC stream sender.
interface mac_stream_sender_if #(
  parameter int unsigned CNT_W = 16
);
  import mac_stream_pkg::*;

  logic                CMD_VALID;
  logic                CMD_READY;
  logic [BEAT_W-1:0]   CMD_BIAS;
  logic [CNT_W-1:0]    CMD_COUNT;

  logic                OP_VALID;
  logic                OP_READY;
  logic [OPND_W-1:0]   OP_A;
  logic [OPND_W-1:0]   OP_B;

  logic                MO_AXIS_TVALID;
  logic [BEAT_W-1:0]   MO_AXIS_TDATA;
  logic                MO_AXIS_TLAST;
  logic                MO_AXIS_TREADY;

  logic                BUSY;

  // Sender side: consumes descriptors/operands, drives the stream.
  modport master (
    input  CMD_VALID, CMD_BIAS, CMD_COUNT,
    input  OP_VALID, OP_A, OP_B,
    input  MO_AXIS_TREADY,
    output CMD_READY, OP_READY,
    output MO_AXIS_TVALID, MO_AXIS_TDATA, MO_AXIS_TLAST,
    output BUSY
  );

  // Environment side: upstream producers and downstream MAC.
  modport slave (
    output CMD_VALID, CMD_BIAS, CMD_COUNT,
    output OP_VALID, OP_A, OP_B,
    output MO_AXIS_TREADY,
    input  CMD_READY, OP_READY,
    input  MO_AXIS_TVALID, MO_AXIS_TDATA, MO_AXIS_TLAST,
    input  BUSY
  );

endinterface

// File: rtl/mac_stream_sender_axis_out_stage.sv
// Single-stage AXI-Stream output register with free/load/hold control.
module axis_out_stage #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_tready,
  output logic              o_tvalid,
  output logic [DATA_W-1:0] o_tdata,
  output logic              o_tlast,
  output logic              o_free_c
);

  logic              r_tvalid;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tlast;
  logic              w_free;

  // Register can take a new beat when empty or when its beat leaves this cycle.
  assign w_free = !r_tvalid || i_tready;

  // Load a new beat, drop valid once drained, otherwise hold data stable.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
    end else if (i_load) begin
      r_tvalid <= 1'b1;
      r_tdata  <= i_data;
      r_tlast  <= i_last;
    end else if (w_free) begin
      r_tvalid <= 1'b0;
    end
  end

  assign o_tvalid = r_tvalid;
  assign o_tdata  = r_tdata;
  assign o_tlast  = r_tlast;
  assign o_free_c = w_free;

endmodule

// File: rtl/mac_stream_sender.sv
// Frames a bias descriptor and N operand pairs into the MAC input stream.
module mac_stream_sender
  import mac_stream_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  mac_stream_sender_if.master bus
);

  state_e             r_state;
  state_e             w_next_state;
  logic [CNT_W-1:0]   r_remaining;
  logic [CNT_W-1:0]   w_next_remaining;

  logic               w_free;
  logic               w_load;
  logic [BEAT_W-1:0]  w_load_data;
  logic               w_load_last;
  logic               w_cmd_ready;
  logic               w_op_ready;
  logic               w_tvalid;

  // Frame state and operand countdown.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state     <= IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_next_state;
      r_remaining <= w_next_remaining;
    end
  end

  // Next state, ready generation and output-stage load selection.
  always_comb begin
    w_next_state     = r_state;
    w_next_remaining = r_remaining;
    w_cmd_ready      = 1'b0;
    w_op_ready       = 1'b0;
    w_load           = 1'b0;
    w_load_data      = '0;
    w_load_last      = 1'b0;

    case (r_state)
      IDLE: begin
        w_cmd_ready = w_free && ARESETN;
        if (bus.CMD_VALID && w_cmd_ready) begin
          w_load      = 1'b1;
          w_load_data = bus.CMD_BIAS;
          w_load_last = (bus.CMD_COUNT == '0);
          if (bus.CMD_COUNT != '0) begin
            w_next_remaining = bus.CMD_COUNT;
            w_next_state     = OPS;
          end
        end
      end
      OPS: begin
        w_op_ready = w_free && ARESETN;
        if (bus.OP_VALID && w_op_ready) begin
          w_load           = 1'b1;
          w_load_data      = pack_pair(bus.OP_A, bus.OP_B);
          w_load_last      = (r_remaining == CNT_W'(1));
          w_next_remaining = r_remaining - CNT_W'(1);
          if (r_remaining == CNT_W'(1)) begin
            w_next_state = IDLE;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  axis_out_stage #(
    .DATA_W (BEAT_W)
  ) u_out_stage (
    .i_clk    (ACLK),
    .i_rst_n  (ARESETN),
    .i_load   (w_load),
    .i_data   (w_load_data),
    .i_last   (w_load_last),
    .i_tready (bus.MO_AXIS_TREADY),
    .o_tvalid (w_tvalid),
    .o_tdata  (bus.MO_AXIS_TDATA),
    .o_tlast  (bus.MO_AXIS_TLAST),
    .o_free_c (w_free)
  );

  assign bus.MO_AXIS_TVALID = w_tvalid;
  assign bus.CMD_READY      = w_cmd_ready;
  assign bus.OP_READY       = w_op_ready;
  assign bus.BUSY           = (r_state == OPS) || w_tvalid;

endmodule

// File: tb/tb_mac_stream_sender.sv
// Scoreboard bench for mac_stream_sender: directed frames, monitor-side checking.
module tb_mac_stream_sender;
  import mac_stream_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  mac_stream_sender_if #(.CNT_W(CNT_W)) bus ();

  mac_stream_sender #(.CNT_W(CNT_W)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] exp_q[$];
  int          beat_cyc[$];
  int          cyc = 0;
  int          beats_seen = 0;
  int          acc = 0;
  int          last_mac = 0;
  bit          in_frame = 1'b0;
  bit          stall_prev = 1'b0;
  logic [16:0] held = '0;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat, checks AXIS hold and MAC sum.
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      stall_prev = 1'b0;
      in_frame   = 1'b0;
    end else begin
      if (stall_prev)
        check("hold", {15'd0, bus.MO_AXIS_TVALID, bus.MO_AXIS_TLAST, bus.MO_AXIS_TDATA},
              {15'd0, 1'b1, held});
      if (bus.MO_AXIS_TVALID && !bus.MO_AXIS_TREADY)
        check("stall_ready", {30'd0, bus.CMD_READY, bus.OP_READY}, 32'd0);
      if (bus.MO_AXIS_TVALID && bus.MO_AXIS_TREADY) begin
        logic [16:0] e;
        int pa, pb;
        beats_seen++;
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got 0x%0h last=%0b expected none",
                   bus.MO_AXIS_TDATA, bus.MO_AXIS_TLAST);
        end else begin
          e = exp_q.pop_front();
          check("beat", {15'd0, bus.MO_AXIS_TLAST, bus.MO_AXIS_TDATA}, {15'd0, e});
        end
        if (!in_frame) begin
          acc      = $signed(bus.MO_AXIS_TDATA);
          in_frame = 1'b1;
        end else begin
          pa  = $signed(bus.MO_AXIS_TDATA[15:8]);
          pb  = $signed(bus.MO_AXIS_TDATA[7:0]);
          acc = acc + pa * pb;
        end
        if (bus.MO_AXIS_TLAST) begin
          last_mac = acc;
          in_frame = 1'b0;
        end
      end
      stall_prev = bus.MO_AXIS_TVALID && !bus.MO_AXIS_TREADY;
      held       = {bus.MO_AXIS_TLAST, bus.MO_AXIS_TDATA};
    end
  end

  task automatic send_cmd(input logic [15:0] bias, input logic [CNT_W-1:0] cnt);
    bit ok = 1'b0;
    bus.CMD_VALID = 1'b1;
    bus.CMD_BIAS  = bias;
    bus.CMD_COUNT = cnt;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (bus.CMD_READY) begin
        ok = 1'b1;
        break;
      end
    end
    check("cmd_handshake", {31'd0, ok}, 32'd1);
    @(posedge ACLK);
    #1;
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b);
    bit ok = 1'b0;
    bus.OP_VALID = 1'b1;
    bus.OP_A     = a;
    bus.OP_B     = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (bus.OP_READY) begin
        ok = 1'b1;
        break;
      end
    end
    check("op_handshake", {31'd0, ok}, 32'd1);
    @(posedge ACLK);
    #1;
    bus.OP_VALID = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge ACLK);
      #2;
      if (exp_q.size() == 0 && !bus.MO_AXIS_TVALID) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pat;
    int         b0;

    bus.CMD_VALID      = 1'b0;
    bus.CMD_BIAS       = '0;
    bus.CMD_COUNT      = '0;
    bus.OP_VALID       = 1'b0;
    bus.OP_A           = '0;
    bus.OP_B           = '0;
    bus.MO_AXIS_TREADY = 1'b1;

    // Reset values
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_stream", {15'd0, bus.MO_AXIS_TVALID, bus.MO_AXIS_TLAST, bus.MO_AXIS_TDATA}, 32'd0);
    check("rst_ready_busy", {29'd0, bus.CMD_READY, bus.OP_READY, bus.BUSY}, 32'd0);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
    check("idle_cmd_ready", {31'd0, bus.CMD_READY}, 32'd1);

    // Basic frame: bias 5, (-10,5), (25,100)
    exp_q.push_back({1'b0, 16'h0005});
    exp_q.push_back({1'b0, 16'hF605});
    exp_q.push_back({1'b1, 16'h1964});
    send_cmd(16'h0005, 16'd2);
    send_op(8'hF6, 8'h05);
    send_op(8'h19, 8'h64);
    drain();
    check("mac_result", last_mac, 32'd2455);
    check("busy_after_frame", {31'd0, bus.BUSY}, 32'd0);

    // Zero-length frame, with a stray operand offered that must be ignored
    bus.OP_VALID = 1'b1;
    bus.OP_A     = 8'h55;
    bus.OP_B     = 8'h55;
    exp_q.push_back({1'b1, 16'hF830});
    send_cmd(16'hF830, 16'd0);
    bus.OP_VALID = 1'b1;
    check("zero_len_beat_busy", {30'd0, bus.MO_AXIS_TVALID, bus.BUSY}, 32'd3);
    check("zero_len_ready", {30'd0, bus.CMD_READY, bus.OP_READY}, 32'd2);
    drain();
    repeat (3) @(posedge ACLK);
    #1;
    check("zero_len_no_op", {31'd0, bus.OP_READY}, 32'd0);
    bus.OP_VALID = 1'b0;

    // Backpressure: N=3, TREADY 1,0,0,1,0,1,1
    exp_q.push_back({1'b0, 16'h0100});
    exp_q.push_back({1'b0, 16'h0102});
    exp_q.push_back({1'b0, 16'h0304});
    exp_q.push_back({1'b1, 16'h0506});
    b0  = beats_seen;
    pat = 7'b1101001;
    fork
      begin
        send_cmd(16'h0100, 16'd3);
        send_op(8'h01, 8'h02);
        send_op(8'h03, 8'h04);
        send_op(8'h05, 8'h06);
      end
      begin
        for (int i = 0; i < 7; i++) begin
          bus.MO_AXIS_TREADY = pat[i];
          @(posedge ACLK);
          #1;
        end
        bus.MO_AXIS_TREADY = 1'b1;
      end
    join
    drain();
    check("bp_beat_count", beats_seen - b0, 32'd4);

    // Back-to-back frames on consecutive cycles
    exp_q.push_back({1'b0, 16'h0001});
    exp_q.push_back({1'b1, 16'h0203});
    exp_q.push_back({1'b0, 16'hFFFF});
    exp_q.push_back({1'b1, 16'h8080});
    beat_cyc.delete();
    send_cmd(16'h0001, 16'd1);
    send_op(8'h02, 8'h03);
    send_cmd(16'hFFFF, 16'd1);
    send_op(8'h80, 8'h80);
    drain();
    check("b2b_beats", beat_cyc.size(), 32'd4);
    if (beat_cyc.size() == 4)
      check("b2b_span", beat_cyc[3] - beat_cyc[0], 32'd3);

    // Operand gaps: two idle cycles between pairs
    exp_q.push_back({1'b0, 16'h0009});
    exp_q.push_back({1'b0, 16'h0101});
    exp_q.push_back({1'b0, 16'h0202});
    exp_q.push_back({1'b1, 16'h0303});
    send_cmd(16'h0009, 16'd3);
    send_op(8'h01, 8'h01);
    for (int g = 0; g < 2; g++) begin
      @(posedge ACLK);
      #1;
      check("gap1_idle", {30'd0, bus.MO_AXIS_TVALID, bus.BUSY}, 32'd1);
    end
    send_op(8'h02, 8'h02);
    for (int g = 0; g < 2; g++) begin
      @(posedge ACLK);
      #1;
      check("gap2_idle", {30'd0, bus.MO_AXIS_TVALID, bus.BUSY}, 32'd1);
    end
    send_op(8'h03, 8'h03);
    check("gap_last_busy", {31'd0, bus.BUSY}, 32'd1);
    drain();
    check("gap_done_busy", {31'd0, bus.BUSY}, 32'd0);

    // Reset mid-frame after bias and one of three pairs
    exp_q.push_back({1'b0, 16'h0011});
    exp_q.push_back({1'b0, 16'h0404});
    send_cmd(16'h0011, 16'd3);
    send_op(8'h04, 8'h04);
    ARESETN = 1'b0;
    @(posedge ACLK);
    #1;
    check("midrst_stream", {15'd0, bus.MO_AXIS_TVALID, bus.MO_AXIS_TLAST, bus.MO_AXIS_TDATA}, 32'd0);
    check("midrst_ready_busy", {29'd0, bus.CMD_READY, bus.OP_READY, bus.BUSY}, 32'd0);
    exp_q.delete();
    ARESETN = 1'b1;
    #1;
    check("post_rst_idle", {30'd0, bus.CMD_READY, bus.OP_READY}, 32'd2);
    exp_q.push_back({1'b1, 16'h0007});
    send_cmd(16'h0007, 16'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
